s641_sig_misr: RTL and testbench

Response compactor for the s641 sequential core: captures the core's 24 primary outputs on every clock of a test run and folds them into a 24-bit multiple-input signature register (MISR). It sits directly downstream of s641 and runs on the same clock. A start/busy/done handshake and a programmable cycle count frame each run. The final signature is held for readout or for optional on-chip comparison.

---
 rtl/s641_sig_misr.sv | 61 ++++++
 tb/tb_s641_sig_misr.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/s641_sig_misr.sv
// s641_sig_misr: 24-bit MISR response compactor for s641; define S641_MISR_CMP_EN for on-chip golden compare (golden/pass ports)
module s641_sig_misr #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY = 24'hC20001
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] resp,
`ifdef S641_MISR_CMP_EN
  input  logic [WIDTH-1:0] golden,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] cycles_left
`ifdef S641_MISR_CMP_EN
  ,
  output logic             pass
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] sig, sig_next;
  logic [CNT_W-1:0] cnt;
  logic accept, last;
  assign accept = start && (state != RUN);
  assign last = (state == RUN) && (cnt == CNT_W'(1));
  assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ resp;
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign signature = sig;
  assign cycles_left = cnt;
  // run framing: load seed/count on accepted start, fold one response per RUN cycle
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      state <= IDLE;
      sig <= '0;
      cnt <= '0;
    end else if (accept) begin
      sig <= seed;
      cnt <= num_cycles;
      state <= (num_cycles != '0) ? RUN : DONE;
    end else if (state == RUN) begin
      sig <= sig_next;
      cnt <= cnt - CNT_W'(1);
      state <= last ? DONE : RUN;
    end
`ifdef S641_MISR_CMP_EN
  // verdict against golden captured on the edge that enters DONE; zero-length runs compare the seed
  always_ff @(posedge CK or posedge RST)
    if (RST) pass <= 1'b0;
    else if (accept) pass <= (num_cycles == '0) && (seed == golden);
    else if (last) pass <= (sig_next == golden);
`endif
endmodule

// File: tb/tb_s641_sig_misr.sv
// tb_s641_sig_misr: randomized self-checking bench for s641_sig_misr against a GF(2) polynomial model
module tb_s641_sig_misr;
  localparam int W = 24;
  localparam int C = 16;
  localparam logic [W-1:0] P = 24'hC20001;
  logic CK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic [C-1:0] num_cycles = '0;
  logic [W-1:0] seed = '0;
  logic [W-1:0] resp = '0;
  logic busy, done;
  logic [W-1:0] signature;
  logic [C-1:0] cycles_left;
`ifdef S641_MISR_CMP_EN
  logic [W-1:0] golden = '0;
  logic pass;
`endif
  int n_vec = 0;
  int n_bad = 0;
  always #5 CK = ~CK;
  s641_sig_misr dut (
    .CK(CK),
    .RST(RST),
    .start(start),
    .num_cycles(num_cycles),
    .seed(seed),
    .resp(resp),
`ifdef S641_MISR_CMP_EN
    .golden(golden),
    .pass(pass),
`endif
    .busy(busy),
    .done(done),
    .signature(signature),
    .cycles_left(cycles_left)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // signature polynomial times x, reduced mod x^24+x^23+x^22+x^17+1, plus the response
  function automatic logic [W-1:0] fold(input logic [W-1:0] s, input logic [W-1:0] r);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ {1'b1, P};
    return t[W-1:0] ^ r;
  endfunction
  task automatic run(input logic [W-1:0] sd, input int n, input bit rnd, input logic [W-1:0] fr, input bit match);
    logic [W-1:0] rs[$];
    logic [W-1:0] e;
    e = sd;
    for (int i = 0; i < n; i++) begin
      rs.push_back(rnd ? W'($urandom) : fr);
      e = fold(e, rs[i]);
    end
    @(negedge CK);
    start = 1'b1;
    num_cycles = C'(n);
    seed = sd;
    resp = W'($urandom);
`ifdef S641_MISR_CMP_EN
    golden = match ? e : ~e;
`endif
    @(posedge CK);
    #1;
    chk("acc_busy", busy, n != 0);
    chk("acc_done", done, n == 0);
    chk("acc_cnt", cycles_left, n);
    chk("acc_sig", signature, sd);
`ifdef S641_MISR_CMP_EN
    chk("acc_pass", pass, (n == 0) && match);
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge CK);
      start = rnd && ($urandom_range(0, 2) == 0);
      num_cycles = C'($urandom);
      seed = W'($urandom);
      resp = rs[i];
      @(posedge CK);
      #1;
      chk("run_cnt", cycles_left, n - 1 - i);
      chk("run_busy", busy, i < n - 1);
      chk("run_done", done, i == n - 1);
`ifdef S641_MISR_CMP_EN
      chk("run_pass", pass, (i == n - 1) && match);
`endif
    end
    chk("end_sig", signature, e);
    @(negedge CK);
    start = 1'b0;
    resp = W'($urandom);
    repeat (2) @(posedge CK);
    #1;
    chk("hold_done", done, 1);
    chk("hold_busy", busy, 0);
    chk("hold_sig", signature, e);
  endtask
  initial begin
    repeat (2) @(posedge CK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cnt", cycles_left, 0);
    @(negedge CK);
    RST = 1'b0;
    run(24'h000000, 1, 1'b0, 24'h000001, 1'b1);
    chk("step_sig", signature, 24'h000001);
    run(24'h800000, 1, 1'b0, 24'h000000, 1'b1);
    chk("fb_sig", signature, 24'hC20001);
    run(24'h800000, 1, 1'b0, 24'h000000, 1'b0);
    run(24'h123456, 0, 1'b0, 24'h000000, 1'b1);
    chk("zero_sig", signature, 24'h123456);
    run(W'($urandom), 5, 1'b1, 24'h0, 1'b1);
    @(posedge CK);
    #3;
    RST = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_sig", signature, 0);
    chk("async_cnt", cycles_left, 0);
    @(negedge CK);
    RST = 1'b0;
    start = 1'b1;
    num_cycles = 16'd5;
    seed = W'($urandom) | 24'h1;
    resp = W'($urandom);
    @(posedge CK);
    @(negedge CK);
    start = 1'b0;
    repeat (2) @(posedge CK);
    #2;
    chk("abort_pre_busy", busy, 1);
    RST = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sig", signature, 0);
    chk("abort_cnt", cycles_left, 0);
    @(negedge CK);
    RST = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk("abort_idle_done", done, 0);
    chk("abort_idle_sig", signature, 0);
    repeat (25) run(W'($urandom), $urandom_range(0, 12), 1'b1, 24'h0, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
